dsm_rx_demod: RTL and testbench
===============================

# dsm_rx_demod

Receive-side counterpart of the beamformer transmit chain. Accepts one channel's 2-bit ternary delta-sigma bitstream, the same code the transmit DSM emits. Down-converts it with the fs/4 quadrature LO (cos 1,0,-1,0; sin 0,1,0,-1). Decimates each branch with a 3-stage CIC to produce 10-bit signed I/Q baseband samples, with a one-cycle valid strobe. Sits between the per-element bitstream capture and downstream baseband processing, one instance per element.

## Interface
- DECIM, 16: decimation ratio R; integer ≥2.
- OUT_SHIFT, 3: arithmetic right shift applied to the CIC output before 10-bit saturation.
- ACC_W, 2+3*$clog2(DECIM): CIC register width (14 at defaults); derived, not overridden.

- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  qualifies dsm_in this cycle.
- dsm_in  input  2  ternary code: 01=+1, 10=-1, 00=0, 11=illegal (decoded as 0).
- lo_sync  input  1  synchronous restart of LO phase, decimation count and filter state.
- i_out  output  10  signed I sample.
- q_out  output  10  signed Q sample.
- out_valid  output  1  one-cycle pulse when i_out/q_out update.
- err_cnt  output  8  saturating count of illegal codes.

## Operation
- Stage 0: dsm_in and in_valid are registered (d_q, v_q).
- LO phase: a 2-bit counter advances only on v_q.
- LO value by phase:
  - Phase 0: cos=+1, sin=0.
  - Phase 1: cos=0, sin=+1.
  - Phase 2: cos=-1, sin=0.
  - Phase 3: cos=0, sin=-1.
- Mix: mi = d·cos and mq = d·sin, each in {-1,0,+1}. The sign is extended to ACC_W.
- Integrators: three cascaded integrators per branch. They update only on v_q, using modulo-2^ACC_W two's-complement arithmetic. Wrap-around is intended and must not be saturated.
- Decimation counter: counts v_q samples from 0 to DECIM-1.
- Decimation strobe: asserts on a v_q sample while the count equals DECIM-1. The counter then wraps to 0.
- Comb chain: on the cycle after the strobe, the last integrator value passes through three combs (differential delay 1). Each comb delay register captures its input on that cycle only.
- Output:
  - The result y is arithmetically shifted right by OUT_SHIFT.
  - It is then saturated to [-512, 511] and registered into i_out/q_out.
  - out_valid is pulsed at the same time.
- lo_sync clears the LO phase, decimation count, all integrators, comb delays and the pipeline valid bits. i_out/q_out hold their last values.
- Priority: reset > lo_sync > in_valid. A sample presented together with lo_sync is discarded.
- Reset values:
  - All outputs are 0: i_out, q_out, out_valid, err_cnt.
  - All internal state is 0.

## Timing
- Latency: the sample that completes a window is presented with in_valid in cycle k. out_valid is high in cycle k+3 (input register, integrator update, comb/output register).
- Output rate: with continuous in_valid, out_valid is high exactly one cycle in every DECIM cycles.
- in_valid gaps stall the LO, the counter and the integrators. The output cadence stretches accordingly.
- CIC transient: the first three outputs after reset or lo_sync are transient. Outputs from the 4th onward are steady-state exact.
- Gain: steady-state gain is DECIM^3 before the shift. Mixing halves the effective DC gain, so a matched input yields DECIM^3/2.

## Configuration
- Macro: DSM_RX_ERRCNT_EN.
- Defined: err_cnt increments on each v_q sample carrying code 11. It saturates at 255 and is cleared by reset only (not by lo_sync).
- Undefined: the counter logic is absent and err_cnt is tied to 0. Code 11 is still decoded as 0.

## Structure
- Shared package dsm_pkg holds:
  - code constants DSM_POS, DSM_NEG, DSM_ZERO, DSM_ILL;
  - the LO phase enumeration;
  - the signed saturate-to-10-bit function.
- Sub-module cic_decim3: three integrators plus three combs, parameterised by ACC_W. It takes a sample enable and a decimation strobe. It is instantiated once for I and once for Q. The top holds the input register, LO, decimation counter, mixer, output saturation and error counter.

## Test plan
- Continuous in_valid, repeating codes 01,00,10,00 from phase 0, defaults → from the 4th out_valid onward, i_out=256 and q_out=0; out_valid exactly every 16 cycles.
- Pattern 00,01,00,10 → q_out=256, i_out=0. Pattern 10,00,01,00 → i_out=-256.
- OUT_SHIFT=2 with pattern 01,00,10,00 → i_out saturates to 511. Pattern 10,00,01,00 → -512.
- Single sample with in_valid=1 completing a window in cycle k → out_valid high in cycle k+3 only. Toggle in_valid 50% → output period 32 cycles and identical values.
- lo_sync asserted mid-window, together with in_valid → that sample is dropped. The next out_valid comes after 16 more valid samples, and the transient restarts.
- Inject 300 code-11 samples → err_cnt=255 with DSM_RX_ERRCNT_EN defined, 0 when undefined. i_out/q_out match the same stream with those samples replaced by 00.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared definitions for the receive-side delta-sigma demodulator:
// ternary code constants, the fs/4 LO phase enumeration and the
// signed saturate-to-10-bit helper used on the baseband outputs.
package dsm_pkg;

    localparam logic [1:0] DSM_ZERO = 2'b00;
    localparam logic [1:0] DSM_POS  = 2'b01;
    localparam logic [1:0] DSM_NEG  = 2'b10;
    localparam logic [1:0] DSM_ILL  = 2'b11;

    // fs/4 LO phase: cos = 1,0,-1,0 and sin = 0,1,0,-1 across the four phases
    typedef enum logic [1:0] {
        LO_PH0 = 2'd0,
        LO_PH1 = 2'd1,
        LO_PH2 = 2'd2,
        LO_PH3 = 2'd3
    } lo_phase_t;

    // Clamp a signed value into the 10-bit range [-512, 511]
    function automatic logic signed [9:0] sat10(input logic signed [31:0] v);
        if (v > 32'sd511) begin
            return 10'sd511;
        end else if (v < -32'sd512) begin
            return 10'sh200;
        end else begin
            return 10'(v);
        end
    endfunction

endpackage

// File: rtl/cic_decim3.sv
// Three-stage CIC decimator core: three integrators running at the input
// sample rate plus three differential-delay-1 combs evaluated once per
// decimation window. Integrators wrap modulo 2^ACC_W on purpose; the comb
// differences recover the exact result as long as it fits in ACC_W bits.
module cic_decim3 #(
    parameter int ACC_W = 14
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic                    dump_en,
    input  logic signed [ACC_W-1:0] x,
    output logic signed [ACC_W-1:0] y
);

    logic signed [ACC_W-1:0] int1, int2, int3;
    logic signed [ACC_W-1:0] dly1, dly2, dly3;
    logic signed [ACC_W-1:0] c1, c2;

    // Integrator cascade; each stage accumulates the previous stage's registered value
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
        end else if (sample_en) begin
            int1 <= int1 + x;
            int2 <= int2 + int1;
            int3 <= int3 + int2;
        end
    end

    // Comb differences on the decimated integrator value
    always_comb begin
        c1 = int3 - dly1;
        c2 = c1 - dly2;
        y  = c2 - dly3;
    end

    // Comb delay registers advance only on the dump cycle
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            dly1 <= '0;
            dly2 <= '0;
            dly3 <= '0;
        end else if (dump_en) begin
            dly1 <= int3;
            dly2 <= c1;
            dly3 <= c2;
        end
    end

endmodule

// File: rtl/dsm_rx_demod.sv
// Receive demodulator for one element: registers the ternary bitstream,
// mixes it with the fs/4 quadrature LO, decimates each branch with a
// 3-stage CIC and emits saturated 10-bit I/Q with a one-cycle strobe.
// Optional illegal-code counter is built when DSM_RX_ERRCNT_EN is defined.
module dsm_rx_demod
    import dsm_pkg::*;
#(
    parameter int   DECIM     = 16,
    parameter int   OUT_SHIFT = 3,
    localparam int  ACC_W     = 2 + 3 * $clog2(DECIM)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        dsm_in,
    input  logic              lo_sync,
    output logic signed [9:0] i_out,
    output logic signed [9:0] q_out,
    output logic              out_valid,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = $clog2(DECIM);

    logic [1:0]              d_q;
    logic                    v_q;
    lo_phase_t               phase;
    logic [CNT_W-1:0]        cnt;
    logic                    strobe;
    logic                    strobe_q;
    logic signed [ACC_W-1:0] d_ext, mi, mq;
    logic signed [ACC_W-1:0] i_y, q_y, i_sh, q_sh;
    logic                    samp_en;

    // Input register; lo_sync discards the sample presented with it
    always_ff @(posedge clock) begin
        if (reset) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else if (lo_sync) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else begin
            d_q <= dsm_in;
            v_q <= in_valid;
        end
    end

    assign samp_en = v_q && !lo_sync;
    assign strobe  = samp_en && (cnt == CNT_W'(DECIM - 1));

    // LO phase, decimation count and dump strobe pipeline bit
    always_ff @(posedge clock) begin
        if (reset || lo_sync) begin
            phase    <= LO_PH0;
            cnt      <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
            if (samp_en) begin
                phase <= lo_phase_t'(phase + 2'd1);
                cnt   <= strobe ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Decode the ternary code (illegal code counts as zero) and mix with the LO
    always_comb begin
        d_ext = '0;
        case (d_q)
            DSM_POS: d_ext = ACC_W'(1);
            DSM_NEG: d_ext = '1;
            default: d_ext = '0;
        endcase
        mi = '0;
        mq = '0;
        case (phase)
            LO_PH0:  mi = d_ext;
            LO_PH1:  mq = d_ext;
            LO_PH2:  mi = -d_ext;
            LO_PH3:  mq = -d_ext;
            default: begin
                mi = '0;
                mq = '0;
            end
        endcase
    end

    cic_decim3 #(.ACC_W(ACC_W)) u_cic_i (
        .clock     (clock),
        .reset     (reset),
        .clear     (lo_sync),
        .sample_en (samp_en),
        .dump_en   (strobe_q),
        .x         (mi),
        .y         (i_y)
    );

    cic_decim3 #(.ACC_W(ACC_W)) u_cic_q (
        .clock     (clock),
        .reset     (reset),
        .clear     (lo_sync),
        .sample_en (samp_en),
        .dump_en   (strobe_q),
        .x         (mq),
        .y         (q_y)
    );

    assign i_sh = i_y >>> OUT_SHIFT;
    assign q_sh = q_y >>> OUT_SHIFT;

    // Output register: scale, saturate and strobe once per decimation window
    always_ff @(posedge clock) begin
        if (reset) begin
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
        end else if (lo_sync) begin
            out_valid <= 1'b0;
        end else if (strobe_q) begin
            i_out     <= sat10(32'(i_sh));
            q_out     <= sat10(32'(q_sh));
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef DSM_RX_ERRCNT_EN
    logic [7:0] err_q;

    // Saturating count of illegal codes; only reset clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else if (samp_en && (d_q == DSM_ILL) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dsm_rx_demod.sv
// Directed bench for dsm_rx_demod: a default instance and an OUT_SHIFT=2
// instance share the same stimulus. Expected values are hand-derived.
module tb_dsm_rx_demod;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic [1:0]        dsm_in;
    logic              lo_sync;
    logic signed [9:0] i_out, q_out, i_out2, q_out2;
    logic              out_valid, out_valid2;
    logic [7:0]        err_cnt, err_cnt2;

    int n_cmp;
    int n_fail;
    int cyc;

    int obs_cyc[$];
    int obs_i[$];
    int obs_q[$];
    int obs_i2[$];
    int obs_q2[$];

    dsm_rx_demod dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .dsm_in    (dsm_in),
        .lo_sync   (lo_sync),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid),
        .err_cnt   (err_cnt)
    );

    dsm_rx_demod #(.OUT_SHIFT(2)) dut_s2 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .dsm_in    (dsm_in),
        .lo_sync   (lo_sync),
        .i_out     (i_out2),
        .q_out     (q_out2),
        .out_valid (out_valid2),
        .err_cnt   (err_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs, advance past the edge and log any output strobe
    task automatic tick(input logic [1:0] c, input logic v, input logic s);
        dsm_in   = c;
        in_valid = v;
        lo_sync  = s;
        @(posedge clock);
        #1;
        cyc++;
        if (out_valid) begin
            obs_cyc.push_back(cyc);
            obs_i.push_back(int'(i_out));
            obs_q.push_back(int'(q_out));
            obs_i2.push_back(int'(i_out2));
            obs_q2.push_back(int'(q_out2));
        end
    endtask

    task automatic clear_obs();
        obs_cyc.delete();
        obs_i.delete();
        obs_q.delete();
        obs_i2.delete();
        obs_q2.delete();
    endtask

    task automatic resync();
        tick(2'b00, 1'b0, 1'b1);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        clear_obs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2'b01, 1'b1, 1'b0);
        tick(2'b11, 1'b1, 1'b0);
        tick(2'b10, 1'b1, 1'b0);
        n_cmp++;
        if (i_out !== 10'sd0 || q_out !== 10'sd0 || out_valid !== 1'b0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_dut: i=%0d q=%0d v=%0b err=%0d required all 0", i_out, q_out, out_valid, err_cnt);
        end
        n_cmp++;
        if (i_out2 !== 10'sd0 || q_out2 !== 10'sd0 || out_valid2 !== 1'b0 || err_cnt2 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_s2: i=%0d q=%0d v=%0b err=%0d required all 0", i_out2, q_out2, out_valid2, err_cnt2);
        end
        reset = 1'b0;
        clear_obs();
    endtask

    // 128 samples of a period-4 pattern (8 windows), optionally with an idle cycle after each
    task automatic test_pattern(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                                input logic [1:0] c3, input bit gap, input int ei, input int eq,
                                input int ei2, input int eq2, input string name);
        logic [1:0] pat[4];
        int period;
        pat[0] = c0;
        pat[1] = c1;
        pat[2] = c2;
        pat[3] = c3;
        period = gap ? 32 : 16;
        resync();
        for (int k = 0; k < 128; k++) begin
            tick(pat[k % 4], 1'b1, 1'b0);
            if (gap) tick(2'b00, 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) tick(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if (obs_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL %s_count: got %0d outputs, required 8", name, obs_cyc.size());
        end else begin
            for (int k = 1; k < 8; k++) begin
                n_cmp++;
                if (obs_cyc[k] - obs_cyc[k-1] != period) begin
                    n_fail++;
                    $display("FAIL %s_period[%0d]: got %0d cycles, required %0d", name, k, obs_cyc[k] - obs_cyc[k-1], period);
                end
            end
            for (int k = 3; k < 8; k++) begin
                n_cmp++;
                if (obs_i[k] != ei || obs_q[k] != eq) begin
                    n_fail++;
                    $display("FAIL %s_iq[%0d]: got i=%0d q=%0d, required i=%0d q=%0d", name, k, obs_i[k], obs_q[k], ei, eq);
                end
                n_cmp++;
                if (obs_i2[k] != ei2 || obs_q2[k] != eq2) begin
                    n_fail++;
                    $display("FAIL %s_shift2[%0d]: got i=%0d q=%0d, required i=%0d q=%0d", name, k, obs_i2[k], obs_q2[k], ei2, eq2);
                end
            end
        end
    endtask

    // Window-completing sample isolated by idle cycles: strobe three cycles later, once
    task automatic test_latency();
        int k_cyc;
        logic [1:0] pat[4];
        pat[0] = 2'b01;
        pat[1] = 2'b00;
        pat[2] = 2'b10;
        pat[3] = 2'b00;
        resync();
        for (int k = 0; k < 15; k++) tick(pat[k % 4], 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) tick(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if (obs_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL latency_early: got %0d outputs before window end, required 0", obs_cyc.size());
        end
        tick(pat[3], 1'b1, 1'b0);
        // the edge just taken closes cycle k; out_valid is visible after two more edges
        k_cyc = cyc;
        for (int k = 0; k < 6; k++) tick(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if (obs_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL latency_count: got %0d outputs, required 1", obs_cyc.size());
        end else begin
            n_cmp++;
            if (obs_cyc[0] != k_cyc + 2) begin
                n_fail++;
                $display("FAIL latency_cycle: got edge %0d, required %0d", obs_cyc[0], k_cyc + 2);
            end
        end
    endtask

    // lo_sync with a sample mid-window: sample dropped, window and transient restart
    task automatic test_lo_sync();
        int k_cyc;
        logic [1:0] pat[4];
        pat[0] = 2'b01;
        pat[1] = 2'b00;
        pat[2] = 2'b10;
        pat[3] = 2'b00;
        resync();
        for (int k = 0; k < 10; k++) tick(pat[k % 4], 1'b1, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b10, 1'b1, 1'b1);
        k_cyc = 0;
        for (int k = 0; k < 64; k++) begin
            tick(pat[k % 4], 1'b1, 1'b0);
            if (k == 15) k_cyc = cyc;
        end
        for (int k = 0; k < 4; k++) tick(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if (obs_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL sync_count: got %0d outputs, required 4", obs_cyc.size());
        end else begin
            n_cmp++;
            if (obs_cyc[0] != k_cyc + 2) begin
                n_fail++;
                $display("FAIL sync_first_cycle: got edge %0d, required %0d", obs_cyc[0], k_cyc + 2);
            end
            // From zeroed state with mixed input 1,0,1,0,...: integrator 1 after s samples is
            // ceil(s/2); integrator 3 at the first dump is 308, and 308 >>> 3 = 38.
            n_cmp++;
            if (obs_i[0] != 38 || obs_q[0] != 0) begin
                n_fail++;
                $display("FAIL sync_transient: got i=%0d q=%0d, required i=38 q=0", obs_i[0], obs_q[0]);
            end
            n_cmp++;
            if (obs_i[3] != 256 || obs_q[3] != 0) begin
                n_fail++;
                $display("FAIL sync_steady: got i=%0d q=%0d, required i=256 q=0", obs_i[3], obs_q[3]);
            end
        end
    endtask

    // 300 illegal codes interleaved where zeros would be; output must match the 01,00,10,00 stream
    task automatic test_errcnt();
        logic [1:0] pat[4];
        int exp_mid;
        int exp_end;
        pat[0] = 2'b01;
        pat[1] = 2'b11;
        pat[2] = 2'b10;
        pat[3] = 2'b11;
`ifdef DSM_RX_ERRCNT_EN
        exp_mid = 8;
        exp_end = 255;
`else
        exp_mid = 0;
        exp_end = 0;
`endif
        reset = 1'b1;
        tick(2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        clear_obs();
        for (int k = 0; k < 16; k++) tick(pat[k % 4], 1'b1, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        tick(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if (int'(err_cnt) != exp_mid) begin
            n_fail++;
            $display("FAIL err_mid: got %0d, required %0d", err_cnt, exp_mid);
        end
        for (int k = 16; k < 600; k++) tick(pat[k % 4], 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick(2'b00, 1'b0, 1'b0);
        n_cmp++;
        if (int'(err_cnt) != exp_end) begin
            n_fail++;
            $display("FAIL err_end: got %0d, required %0d", err_cnt, exp_end);
        end
        n_cmp++;
        if (obs_cyc.size() != 37) begin
            n_fail++;
            $display("FAIL err_out_count: got %0d outputs, required 37", obs_cyc.size());
        end else begin
            for (int k = 3; k < 37; k += 11) begin
                n_cmp++;
                if (obs_i[k] != 256 || obs_q[k] != 0) begin
                    n_fail++;
                    $display("FAIL err_iq[%0d]: got i=%0d q=%0d, required i=256 q=0", k, obs_i[k], obs_q[k]);
                end
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        dsm_in   = 2'b00;
        lo_sync  = 1'b0;
        test_reset();
        test_pattern(2'b01, 2'b00, 2'b10, 2'b00, 1'b0,  256,    0,  511,    0, "i_pos");
        test_pattern(2'b00, 2'b01, 2'b00, 2'b10, 1'b0,    0,  256,    0,  511, "q_pos");
        test_pattern(2'b10, 2'b00, 2'b01, 2'b00, 1'b0, -256,    0, -512,    0, "i_neg");
        test_pattern(2'b00, 2'b10, 2'b00, 2'b01, 1'b0,    0, -256,    0, -512, "q_neg");
        test_pattern(2'b01, 2'b00, 2'b10, 2'b00, 1'b1,  256,    0,  511,    0, "i_gap");
        test_latency();
        test_lo_sync();
        test_errcnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
